// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with Z/V/N flags and a valid/ready handshake.
// Optional saturation on overflow is enabled by defining PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ctrl,
    input  logic             Sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // Each stage consumes the low SEG bits of the operand remnant it receives; the
    // unconsumed high bits and the completed low result bits travel with the op.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned RIN = WIDTH - k * SEG;

        logic [RIN-1:0] a_in;
        logic [RIN-1:0] b_in;
        logic           c_in;
        logic           ctrl_in;
        logic           sign_in;
        logic           vld_in;
        logic [SEG:0]   seg_sum;

        if (k == 0) begin : g_head
            assign a_in    = A;
            assign b_in    = ctrl ? ~B : B;
            assign c_in    = ctrl;
            assign ctrl_in = ctrl;
            assign sign_in = Sign;
            assign vld_in  = in_valid;
        end else begin : g_link
            assign a_in    = g_stage[k-1].g_reg.a_q;
            assign b_in    = g_stage[k-1].g_reg.b_q;
            assign c_in    = g_stage[k-1].g_reg.c_q;
            assign ctrl_in = g_stage[k-1].g_reg.ctrl_q;
            assign sign_in = g_stage[k-1].g_reg.sign_q;
            assign vld_in  = g_stage[k-1].g_reg.vld_q;
        end

        assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        if (k < LAST) begin : g_reg
            logic [RIN-SEG-1:0]   a_q;
            logic [RIN-SEG-1:0]   b_q;
            logic [(k+1)*SEG-1:0] lo_q;
            logic [(k+1)*SEG-1:0] lo_d;
            logic                 c_q;
            logic                 ctrl_q;
            logic                 sign_q;
            logic                 vld_q;

            if (k == 0) begin : g_lo_first
                assign lo_d = seg_sum[SEG-1:0];
            end else begin : g_lo_chain
                assign lo_d = {seg_sum[SEG-1:0], g_stage[k-1].g_reg.lo_q};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    a_q    <= '0;
                    b_q    <= '0;
                    lo_q   <= '0;
                    c_q    <= 1'b0;
                    ctrl_q <= 1'b0;
                    sign_q <= 1'b0;
                end else if (adv) begin
                    vld_q  <= vld_in;
                    a_q    <= a_in[RIN-1:SEG];
                    b_q    <= b_in[RIN-1:SEG];
                    lo_q   <= lo_d;
                    c_q    <= seg_sum[SEG];
                    ctrl_q <= ctrl_in;
                    sign_q <= sign_in;
                end
            end
        end
    end

    logic [WIDTH-1:0] sum_fin;
    logic             c_fin;
    logic             ctrl_fin;
    logic             sign_fin;
    logic             vld_fin;
    logic             a_msb;
    logic             b_msb;
    logic             s_msb;

    if (STAGES == 1) begin : g_res_single
        assign sum_fin = g_stage[0].seg_sum[SEG-1:0];
    end else begin : g_res_multi
        assign sum_fin = {g_stage[LAST].seg_sum[SEG-1:0], g_stage[LAST-1].g_reg.lo_q};
    end

    assign c_fin    = g_stage[LAST].seg_sum[SEG];
    assign ctrl_fin = g_stage[LAST].ctrl_in;
    assign sign_fin = g_stage[LAST].sign_in;
    assign vld_fin  = g_stage[LAST].vld_in;
    assign a_msb    = g_stage[LAST].a_in[SEG-1];
    // Recover the original B sign bit from the effective (possibly inverted) operand.
    assign b_msb    = g_stage[LAST].b_in[SEG-1] ^ ctrl_fin;
    assign s_msb    = sum_fin[WIDTH-1];

    logic [WIDTH-1:0] dout_d;
    logic             z_d;
    logic             v_d;
    logic             n_d;

    always_comb begin
        if (sign_fin) begin
            v_d = ctrl_fin ? ((a_msb != b_msb) && (s_msb != a_msb))
                           : ((a_msb == b_msb) && (s_msb != a_msb));
        end else begin
            // Unsigned subtract: borrow is the inverse of the carry out.
            v_d = ctrl_fin ? ~c_fin : c_fin;
        end
        n_d    = sign_fin ? (s_msb ^ v_d) : (ctrl_fin & v_d);
        dout_d = sum_fin;
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (v_d) begin
            if (sign_fin) begin
                dout_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                dout_d = ctrl_fin ? '0 : '1;
            end
        end
`endif
        z_d = (dout_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            Z         <= 1'b0;
            V         <= 1'b0;
            N         <= 1'b0;
        end else if (adv) begin
            out_valid <= vld_fin;
            if (vld_fin) begin
                dout <= dout_d;
                Z    <= z_d;
                V    <= v_d;
                N    <= n_d;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (STAGES=2 main DUT, STAGES=4 companion).
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        ctrl;
    logic        Sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;
    logic        Z, V, N;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] dout4;
    logic        Z4, V4, N4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .ctrl(ctrl), .Sign(Sign), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .Z(Z), .V(V), .N(N)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .A(A), .B(B),
        .ctrl(ctrl), .Sign(Sign), .out_valid(out_valid4), .out_ready(1'b1),
        .dout(dout4), .Z(Z4), .V(V4), .N(N4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input logic [31:0] ed,
                          input logic ez, input logic ev, input logic en);
        A = a; B = b; ctrl = c; Sign = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " out_valid_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " dout"}, dout, ed);
        check({tag, " Z"}, {31'd0, Z}, {31'd0, ez});
        check({tag, " V"}, {31'd0, V}, {31'd0, ev});
        check({tag, " N"}, {31'd0, N}, {31'd0, en});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ctrl = 1'b0; Sign = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst dout", dout, 32'd0);
        check("rst Z", {31'd0, Z}, 32'd0);
        check("rst V", {31'd0, V}, 32'd0);
        check("rst N", {31'd0, N}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("add5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
`ifdef PIPELINED_ADDSUB_SAT_EN
        run_op("sub0_min", 32'h0, 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("addmax_1", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("usub3_5", 32'd3, 32'd5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
`else
        run_op("sub0_min", 32'h0, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("addmax_1", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("usub3_5", 32'd3, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
`endif
        run_op("usub9_9", 32'd9, 32'd9, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        run_op("cross_seg", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("s4 cross_seg out_valid", {31'd0, out_valid4}, 32'd1);
        check("s4 cross_seg dout", dout4, 32'h0001_0000);
        check("s4 cross_seg V", {31'd0, V4}, 32'd0);
`ifdef PIPELINED_ADDSUB_SAT_EN
        run_op("uadd_carry", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        run_op("uadd_carry", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
`endif
        run_op("ssub5_7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        tick();

        // Back-to-back stream of 8 ops; op c is A=0x10000000+c*0x101, B=c.
        ctrl = 1'b0; Sign = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                A = 32'h1000_0000 + 32'(c) * 32'h101;
                B = 32'(c);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 8) begin
                check($sformatf("stream%0d out_valid", c - 1), {31'd0, out_valid}, 32'd1);
                check($sformatf("stream%0d dout", c - 1), dout,
                      32'h1000_0000 + 32'(c - 1) * 32'h102);
            end else begin
                check($sformatf("stream idle%0d out_valid", c), {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: three stall edges with P0 at the output.
        A = 32'h100; B = 32'd1; in_valid = 1'b1;
        tick();
        check("bp s0 out_valid", {31'd0, out_valid}, 32'd0);
        A = 32'h200; B = 32'd2;
        tick();
        check("bp p0 dout", dout, 32'h101);
        A = 32'h300; B = 32'd3; out_ready = 1'b0;
        #1;
        check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp stall%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp stall%0d dout", i), dout, 32'h101);
            check($sformatf("bp stall%0d Z", i), {31'd0, Z}, 32'd0);
            check($sformatf("bp stall%0d in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp in_ready release", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp p1 dout", dout, 32'h202);
        A = 32'h400; B = 32'd4;
        tick();
        check("bp p2 dout", dout, 32'h303);
        in_valid = 1'b0;
        tick();
        check("bp p3 out_valid", {31'd0, out_valid}, 32'd1);
        check("bp p3 dout", dout, 32'h404);
        tick();
        check("bp drained out_valid", {31'd0, out_valid}, 32'd0);

        // Reset with ops in flight.
        A = 32'd1; B = 32'd1; in_valid = 1'b1;
        tick();
        A = 32'd2; B = 32'd2;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst dout", dout, 32'd0);
        check("midrst s4 out_valid", {31'd0, out_valid4}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("postrst%0d out_valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("postrst%0d s4 out_valid", i), {31'd0, out_valid4}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
